// File: rtl/vend_pay_ctrl.sv
// Vending machine payment sequencer: latches the selection, accumulates coins,
// runs the dispense handshake and pays change out one coin at a time.
module vend_pay_ctrl #(
    parameter int BAL_W        = 8,
    parameter int MAX_BAL      = 200,
    parameter int DISP_TIMEOUT = 50000,
    parameter int CHANGE_GAP   = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [4:0]       area_flag,
    input  logic [3:0]       goods_index,
    input  logic             coin_valid,
    input  logic [1:0]       coin_value,
    input  logic             dispense_ack,
    output logic             enough_flag,
    output logic [BAL_W-1:0] balance,
    output logic [BAL_W-1:0] price,
    output logic [3:0]       sel_index,
    output logic             dispense_req,
    output logic [3:0]       dispense_id,
    output logic             change_valid,
    output logic [1:0]       change_value,
    output logic             coin_reject,
    output logic             fault,
    output logic             busy
);
    localparam int TMR_W = (DISP_TIMEOUT > 1) ? $clog2(DISP_TIMEOUT) : 1;
    localparam int GAP_W = (CHANGE_GAP > 1) ? $clog2(CHANGE_GAP) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SELECT, S_DISPENSE, S_CHANGE} state_t;

    state_t             r_state, w_state_nxt;
    logic [BAL_W-1:0]   r_bal, w_bal_nxt;
    logic [3:0]         r_sel, w_sel_nxt;
    logic [TMR_W-1:0]   r_tmr, w_tmr_nxt;
    logic [GAP_W-1:0]   r_gap, w_gap_nxt;
    logic               r_chg_vld, w_chg_vld_nxt;
    logic [1:0]         r_chg_val, w_chg_val_nxt;
    logic               r_rej, w_rej_nxt;
    logic               r_fault, w_fault_nxt;

    logic [BAL_W-1:0]   w_coin_amt;
    logic [BAL_W:0]     w_bal_sum;
    logic               w_accept;
    logic [BAL_W-1:0]   w_credit;
    logic [BAL_W-1:0]   w_price;
    logic               w_enough;
    logic               w_goods_ok;
    logic [BAL_W-1:0]   w_den_amt;
    logic [1:0]         w_den_code;

    always_comb begin
        case (coin_value)
            2'b00:   w_coin_amt = BAL_W'(1);
            2'b01:   w_coin_amt = BAL_W'(5);
            2'b10:   w_coin_amt = BAL_W'(10);
            default: w_coin_amt = BAL_W'(20);
        endcase
    end

    always_comb begin
        if (r_sel >= 4'd1 && r_sel <= 4'd4)
            w_price = BAL_W'(3);
        else if (r_sel >= 4'd5 && r_sel <= 4'd8)
            w_price = BAL_W'(5);
        else if (r_sel >= 4'd9 && r_sel <= 4'd12)
            w_price = BAL_W'(8);
        else
            w_price = '0;
    end

    // Greedy change: largest denomination not exceeding the remaining balance
    always_comb begin
        if (r_bal >= BAL_W'(20)) begin
            w_den_amt = BAL_W'(20); w_den_code = 2'b11;
        end else if (r_bal >= BAL_W'(10)) begin
            w_den_amt = BAL_W'(10); w_den_code = 2'b10;
        end else if (r_bal >= BAL_W'(5)) begin
            w_den_amt = BAL_W'(5);  w_den_code = 2'b01;
        end else begin
            w_den_amt = BAL_W'(1);  w_den_code = 2'b00;
        end
    end

    assign w_bal_sum  = {1'b0, r_bal} + {1'b0, w_coin_amt};
    assign w_accept   = coin_valid && (r_state == S_IDLE || r_state == S_SELECT)
                        && (w_bal_sum <= (BAL_W+1)'(MAX_BAL));
    assign w_credit   = w_accept ? w_bal_sum[BAL_W-1:0] : r_bal;
    assign w_enough   = (r_sel != 4'd0) && (r_bal >= w_price);
    assign w_goods_ok = (goods_index != 4'd0) && (goods_index <= 4'd12);

    always_comb begin
        w_state_nxt   = r_state;
        w_bal_nxt     = r_bal;
        w_sel_nxt     = r_sel;
        w_tmr_nxt     = r_tmr;
        w_gap_nxt     = r_gap;
        w_chg_vld_nxt = 1'b0;
        w_chg_val_nxt = 2'b00;
        w_rej_nxt     = coin_valid && !w_accept;
        w_fault_nxt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_bal_nxt = w_credit;
                if (w_goods_ok) begin
                    w_sel_nxt   = goods_index;
                    w_state_nxt = S_SELECT;
                end else if (area_flag == 5'd18 && r_bal != '0) begin
                    w_gap_nxt   = '0;
                    w_state_nxt = S_CHANGE;
                end
            end
            S_SELECT: begin
                // enough is judged on the registered balance; a same-cycle coin is only credited
                if (area_flag == 5'd17 && w_enough) begin
                    w_bal_nxt   = w_credit - w_price;
                    w_tmr_nxt   = '0;
                    w_state_nxt = S_DISPENSE;
                end else if (area_flag == 5'd17 || area_flag == 5'd18) begin
                    w_bal_nxt   = w_credit;
                    w_sel_nxt   = 4'd0;
                    w_gap_nxt   = '0;
                    w_state_nxt = S_CHANGE;
                end else begin
                    w_bal_nxt = w_credit;
                    if (w_goods_ok && goods_index != r_sel)
                        w_sel_nxt = goods_index;
                end
            end
            S_DISPENSE: begin
                if (dispense_ack) begin
                    w_sel_nxt   = 4'd0;
                    w_gap_nxt   = '0;
                    w_state_nxt = S_CHANGE;
                end else if (r_tmr == TMR_W'(DISP_TIMEOUT - 1)) begin
                    w_fault_nxt = 1'b1;
                    w_bal_nxt   = r_bal + w_price;
                    w_sel_nxt   = 4'd0;
                    w_gap_nxt   = '0;
                    w_state_nxt = S_CHANGE;
                end else begin
                    w_tmr_nxt = r_tmr + TMR_W'(1);
                end
            end
            default: begin
                if (r_bal == '0) begin
                    w_state_nxt = S_IDLE;
                end else if (r_gap == '0) begin
                    w_chg_vld_nxt = 1'b1;
                    w_chg_val_nxt = w_den_code;
                    w_bal_nxt     = r_bal - w_den_amt;
                    w_gap_nxt     = GAP_W'(CHANGE_GAP - 1);
                end else begin
                    w_gap_nxt = r_gap - GAP_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= S_IDLE;
            r_bal     <= '0;
            r_sel     <= '0;
            r_tmr     <= '0;
            r_gap     <= '0;
            r_chg_vld <= 1'b0;
            r_chg_val <= 2'b00;
            r_rej     <= 1'b0;
            r_fault   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_bal     <= w_bal_nxt;
            r_sel     <= w_sel_nxt;
            r_tmr     <= w_tmr_nxt;
            r_gap     <= w_gap_nxt;
            r_chg_vld <= w_chg_vld_nxt;
            r_chg_val <= w_chg_val_nxt;
            r_rej     <= w_rej_nxt;
            r_fault   <= w_fault_nxt;
        end
    end

    assign enough_flag  = w_enough;
    assign balance      = r_bal;
    assign price        = w_price;
    assign sel_index    = r_sel;
    assign dispense_req = (r_state == S_DISPENSE);
    assign dispense_id  = (r_state == S_DISPENSE) ? r_sel : 4'd0;
    assign change_valid = r_chg_vld;
    assign change_value = r_chg_val;
    assign coin_reject  = r_rej;
    assign fault        = r_fault;
    assign busy         = (r_state == S_DISPENSE) || (r_state == S_CHANGE);
endmodule
